pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline.
- Generates the global pipeline-register enable (pcEnable) consumed by IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three events: multi-cycle data-memory handshakes for the op held in EX/MEM, load-use bubbles, and branch flushes.
- Detects data-memory timeouts and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline. Produces the global
// pipeline-register enable and the local IF/ID / ID/EX controls for three
// events:
//   * multi-cycle data-memory handshakes for the op held in EX/MEM
//     (global freeze),
//   * load-use hazards (one bubble into ID/EX, PC and IF/ID held),
//   * taken branches resolved in ID (IF/ID flushed to NOP).
// Priority: global freeze > load-use > branch flush.
// A data-memory access that waits longer than TIMEOUT_CYCLES moves the FSM to
// a sticky ERROR state, which only reset can leave. A saturating counter
// records the number of stall cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  max consecutive MEM_WAIT cycles before ERROR (1..255)
//   CNT_W           width of stall_cnt_o
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high
//   IDEX_MemRead_i  ID/EX holds a load
//   IDEX_Rt_i       load destination register in ID/EX
//   IFID_Rs_i       rs of the instruction in IF/ID
//   IFID_Rt_i       rt of the instruction in IF/ID
//   Branch_i        branch taken, resolved in ID
//   mem_req_i       EX/MEM op accesses data memory
//   mem_ack_i       data memory completes the current access this cycle
//   pcEnable_o      global pipeline-register enable (0 freezes all stages)
//   PC_write_o      PC update enable
//   IFID_write_o    IF/ID load enable
//   IFID_flush_o    IF/ID clears to NOP
//   IDEX_bubble_o   ID/EX loads zeroed control
//   mem_busy_o      FSM is in MEM_WAIT
//   error_o         sticky memory-timeout error
//   stall_cnt_o     saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pcEnable_o,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             mem_busy_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_en;
  logic lu;
  logic stall_cycle;

  // Load-use: the load in ID/EX writes a register the IF/ID instruction reads.
  // Register 0 is hard-wired, so it never creates a dependency.
  assign lu = IDEX_MemRead_i
            & (IDEX_Rt_i != 5'd0)
            & ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));

  // Next-state and global enable.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_en      = 1'b1;

    unique case (state_q)
      ST_RUN: begin
        // A zero-wait access (req with ack) passes straight through.
        if (mem_req_i && !mem_ack_i) begin
          pc_en      = 1'b0;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end

      ST_MEM_WAIT: begin
        // The op is frozen in EX/MEM, so mem_req_i carries no new information.
        pc_en = mem_ack_i;
        if (mem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_V) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_ERROR: begin
        pc_en = 1'b0;
      end

      default: begin
        // Unused encoding: recover to RUN with the pipeline frozen.
        pc_en      = 1'b0;
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Stall cycles are counted in RUN and MEM_WAIT only; ERROR freezes the count.
  assign stall_cycle = (state_q != ST_ERROR) & (~pc_en | lu);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Local controls: a global freeze suppresses everything, load-use beats
  // the branch flush (ID re-resolves the branch once the bubble is in).
  assign pcEnable_o    = pc_en;
  assign PC_write_o    = pc_en & ~lu;
  assign IFID_write_o  = pc_en & ~lu;
  assign IDEX_bubble_o = pc_en & lu;
  assign IFID_flush_o  = pc_en & Branch_i & ~lu;

  // Decoded from the state register only, so no input-to-output path.
  assign mem_busy_o  = (state_q == ST_MEM_WAIT);
  assign error_o     = (state_q == ST_ERROR);
  assign stall_cnt_o = stall_cnt_q;

endmodule
